// File: rtl/imu_poll_scheduler_pkg.sv
// Shared types and constants for the IMU poll scheduler.
package imu_sched_pkg;

    localparam int SAMPLE_W = 10;
    localparam int READ_LEN = 6;
    localparam int INIT_LEN = 4;
    localparam int IDX_W    = 2;

    localparam logic [7:0] ACCEL_DATA_REG = 8'h32;
    localparam logic [7:0] GYRO_DATA_REG  = 8'h1D;

    typedef logic signed [SAMPLE_W-1:0] sample_t;

    typedef enum logic [2:0] {
        INIT_REQ,
        INIT_WAIT,
        IDLE,
        ACC_REQ,
        ACC_WAIT,
        GYR_REQ,
        GYR_WAIT,
        PUBLISH
    } sched_state_e;

    // One configuration write; gyro selects the target device.
    typedef struct packed {
        logic       gyro;
        logic [7:0] reg_addr;
        logic [7:0] data;
    } init_entry_t;

    function automatic init_entry_t init_entry(input logic [IDX_W-1:0] idx);
        case (idx)
            2'd0:    return '{gyro: 1'b0, reg_addr: 8'h2D, data: 8'h08};
            2'd1:    return '{gyro: 1'b0, reg_addr: 8'h31, data: 8'h00};
            2'd2:    return '{gyro: 1'b1, reg_addr: 8'h3E, data: 8'h00};
            default: return '{gyro: 1'b1, reg_addr: 8'h16, data: 8'h18};
        endcase
    endfunction

    // Accel is little-endian, low 10 bits of the raw word.
    function automatic sample_t accel_sample(input logic [7:0] lo, input logic [7:0] hi);
        return {hi[1:0], lo};
    endfunction

    // Gyro is big-endian; keep the top 10 bits (raw16 >>> 6).
    function automatic sample_t gyro_sample(input logic [7:0] hi, input logic [7:0] lo);
        return {hi, lo[7:6]};
    endfunction

endpackage

// File: rtl/imu_poll_scheduler_if.sv
// Handshake between the scheduler (master) and the byte-level I2C engine (slave).
interface imu_poll_scheduler_if;
    logic       TxnReq;
    logic       TxnAck;
    logic       TxnRead;
    logic [6:0] TxnDevAddr;
    logic [7:0] TxnRegAddr;
    logic [7:0] TxnWrData;
    logic [2:0] TxnLen;
    logic       RxByteValid;
    logic [7:0] RxByte;
    logic       TxnDone;
    logic       TxnNack;

    modport master (
        output TxnReq, TxnRead, TxnDevAddr, TxnRegAddr, TxnWrData, TxnLen,
        input  TxnAck, RxByteValid, RxByte, TxnDone, TxnNack
    );

    modport slave (
        input  TxnReq, TxnRead, TxnDevAddr, TxnRegAddr, TxnWrData, TxnLen,
        output TxnAck, RxByteValid, RxByte, TxnDone, TxnNack
    );
endinterface

// File: rtl/imu_poll_scheduler_sample_timer.sv
// Free-running sample-period counter; one-cycle tick on the last count.
module imu_sample_timer #(
    parameter int SamplePeriod = 500000
) (
    input  logic clk,
    input  logic rst_n,
    output logic tick_o
);
    localparam int            CW   = (SamplePeriod > 1) ? $clog2(SamplePeriod) : 1;
    localparam logic [CW-1:0] LAST = CW'(SamplePeriod - 1);

    logic [CW-1:0] cnt_q, cnt_d;

    assign tick_o = (cnt_q == LAST);
    assign cnt_d  = tick_o ? '0 : cnt_q + 1'b1;

    // Counter wraps at SamplePeriod-1 and never stops.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) cnt_q <= '0;
        else        cnt_q <= cnt_d;
    end
endmodule

// File: rtl/imu_poll_scheduler.sv
// IMU poll scheduler: writes the config table once, then per sample tick reads
// accel and gyro bursts into a shadow buffer and publishes a complete frame.
module imu_poll_scheduler
    import imu_sched_pkg::*;
#(
    parameter int         SamplePeriod = 500000,
    parameter int         MaxRetries   = 3,
    parameter logic [6:0] AccelAddr    = 7'h53,
    parameter logic [6:0] GyroAddr     = 7'h68
) (
    input  logic                 IMUI2CClock,
    input  logic                 IMUReset_n,
    input  logic                 Enable,
    imu_poll_scheduler_if.master txn,
    output sample_t              AccelX,
    output sample_t              AccelY,
    output sample_t              AccelZ,
    output sample_t              GyroX,
    output sample_t              GyroY,
    output sample_t              GyroZ,
    output logic                 DataValid,
    output logic                 Fault,
    output logic                 Overrun
);
    localparam int RW = $clog2(MaxRetries + 2);

    sched_state_e     state_q, state_d;
    logic [IDX_W-1:0] init_idx_q, init_idx_d;
    logic [RW-1:0]    retry_q, retry_d;
    logic [2:0]       byte_cnt_q, byte_cnt_d;
    logic             req_q, req_d;
    logic             fault_d;
    logic [11:0][7:0] shadow_q;
    logic             tick, in_wait, take_byte, txn_ok, publish;
    logic [2:0]       cnt_eff;
    logic [3:0]       wr_idx;
    init_entry_t      entry;

    imu_sample_timer #(.SamplePeriod(SamplePeriod)) u_timer (
        .clk    (IMUI2CClock),
        .rst_n  (IMUReset_n),
        .tick_o (tick)
    );

    // A byte arriving with TxnDone is counted before success is judged.
    assign in_wait   = (state_q == ACC_WAIT) || (state_q == GYR_WAIT);
    assign take_byte = in_wait && txn.RxByteValid && (byte_cnt_q < 3'(READ_LEN));
    assign cnt_eff   = byte_cnt_q + {2'b0, take_byte};
    assign txn_ok    = !txn.TxnNack && ((state_q == INIT_WAIT) || (cnt_eff == 3'(READ_LEN)));
    assign wr_idx    = ((state_q == GYR_WAIT) ? 4'd6 : 4'd0) + {1'b0, byte_cnt_q};
    assign publish   = (state_q == PUBLISH);
    assign entry     = init_entry(init_idx_q);
    assign req_d     = (state_d == INIT_REQ) || (state_d == ACC_REQ) || (state_d == GYR_REQ);
    assign txn.TxnReq = req_q;

    // Next-state: request/wait sequencing with retry, fault and abort policy.
    always_comb begin
        state_d    = state_q;
        init_idx_d = init_idx_q;
        retry_d    = retry_q;
        byte_cnt_d = take_byte ? cnt_eff : byte_cnt_q;
        fault_d    = Fault;
        case (state_q)
            INIT_REQ: begin
                byte_cnt_d = '0;
                if (req_q && txn.TxnAck) state_d = INIT_WAIT;
            end
            ACC_REQ: begin
                byte_cnt_d = '0;
                if (req_q && txn.TxnAck) state_d = ACC_WAIT;
            end
            GYR_REQ: begin
                byte_cnt_d = '0;
                if (req_q && txn.TxnAck) state_d = GYR_WAIT;
            end
            INIT_WAIT: if (txn.TxnDone) begin
                if (txn_ok || (retry_q == RW'(MaxRetries))) begin
                    // Exhausted init writes fault but the table still advances.
                    fault_d = Fault | !txn_ok;
                    retry_d = '0;
                    if (init_idx_q == IDX_W'(INIT_LEN - 1)) begin
                        state_d = IDLE;
                    end else begin
                        init_idx_d = init_idx_q + 1'b1;
                        state_d    = INIT_REQ;
                    end
                end else begin
                    retry_d = retry_q + 1'b1;
                    state_d = INIT_REQ;
                end
            end
            IDLE: if (tick && Enable) state_d = ACC_REQ;
            ACC_WAIT, GYR_WAIT: if (txn.TxnDone) begin
                retry_d = '0;
                if (!Enable) begin
                    state_d = IDLE;
                end else if (txn_ok) begin
                    state_d = (state_q == ACC_WAIT) ? GYR_REQ : PUBLISH;
                end else if (retry_q < RW'(MaxRetries)) begin
                    retry_d = retry_q + 1'b1;
                    state_d = (state_q == ACC_WAIT) ? ACC_REQ : GYR_REQ;
                end else begin
                    fault_d = 1'b1;
                    state_d = IDLE;
                end
            end
            PUBLISH: state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Request fields, all zero whenever no request is outstanding.
    always_comb begin
        txn.TxnRead    = 1'b0;
        txn.TxnDevAddr = '0;
        txn.TxnRegAddr = '0;
        txn.TxnWrData  = '0;
        txn.TxnLen     = '0;
        if (req_q) begin
            case (state_q)
                INIT_REQ: begin
                    txn.TxnDevAddr = entry.gyro ? GyroAddr : AccelAddr;
                    txn.TxnRegAddr = entry.reg_addr;
                    txn.TxnWrData  = entry.data;
                end
                ACC_REQ: begin
                    txn.TxnRead    = 1'b1;
                    txn.TxnDevAddr = AccelAddr;
                    txn.TxnRegAddr = ACCEL_DATA_REG;
                    txn.TxnLen     = 3'(READ_LEN);
                end
                GYR_REQ: begin
                    txn.TxnRead    = 1'b1;
                    txn.TxnDevAddr = GyroAddr;
                    txn.TxnRegAddr = GYRO_DATA_REG;
                    txn.TxnLen     = 3'(READ_LEN);
                end
                default: ;
            endcase
        end
    end

    // Control registers; reset drops TxnReq immediately.
    always_ff @(posedge IMUI2CClock or negedge IMUReset_n) begin
        if (!IMUReset_n) begin
            state_q    <= INIT_REQ;
            init_idx_q <= '0;
            retry_q    <= '0;
            byte_cnt_q <= '0;
            req_q      <= 1'b0;
            Fault      <= 1'b0;
            Overrun    <= 1'b0;
        end else begin
            state_q    <= state_d;
            init_idx_q <= init_idx_d;
            retry_q    <= retry_d;
            byte_cnt_q <= byte_cnt_d;
            req_q      <= req_d;
            Fault      <= fault_d;
            Overrun    <= tick && Enable && (state_q != IDLE);
        end
    end

    // Shadow capture; samples and DataValid change together on PUBLISH.
    always_ff @(posedge IMUI2CClock or negedge IMUReset_n) begin
        if (!IMUReset_n) begin
            shadow_q  <= '0;
            AccelX    <= '0;
            AccelY    <= '0;
            AccelZ    <= '0;
            GyroX     <= '0;
            GyroY     <= '0;
            GyroZ     <= '0;
            DataValid <= 1'b0;
        end else begin
            if (take_byte) shadow_q[wr_idx] <= txn.RxByte;
            DataValid <= publish;
            if (publish) begin
                AccelX <= accel_sample(shadow_q[0], shadow_q[1]);
                AccelY <= accel_sample(shadow_q[2], shadow_q[3]);
                AccelZ <= accel_sample(shadow_q[4], shadow_q[5]);
                GyroX  <= gyro_sample(shadow_q[6], shadow_q[7]);
                GyroY  <= gyro_sample(shadow_q[8], shadow_q[9]);
                GyroZ  <= gyro_sample(shadow_q[10], shadow_q[11]);
            end
        end
    end
endmodule

// File: tb/tb_imu_poll_scheduler.sv
// Bench for imu_poll_scheduler: engine responder plus a frame-level model.
module tb_imu_poll_scheduler;
    localparam int PERIOD = 200;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       en = 1'b0;
    logic [9:0] ax, ay, az, gx, gy, gz;
    logic       dv, fault, ovr;

    imu_poll_scheduler_if bus();

    imu_poll_scheduler #(.SamplePeriod(PERIOD)) dut (
        .IMUI2CClock (clk),
        .IMUReset_n  (rst_n),
        .Enable      (en),
        .txn         (bus),
        .AccelX      (ax),
        .AccelY      (ay),
        .AccelZ      (az),
        .GyroX       (gx),
        .GyroY       (gy),
        .GyroZ       (gz),
        .DataValid   (dv),
        .Fault       (fault),
        .Overrun     (ovr)
    );

    always #5 clk = ~clk;

    int         n_tests = 0;
    int         n_fail  = 0;
    int         dv_cnt  = 0;
    int         ovr_cnt = 0;
    logic [7:0] byte_q[$];
    logic [7:0] fb [12];
    int         exp_s [6];

    // Pulse counters for DataValid and Overrun.
    always @(posedge clk) begin
        if (dv)  dv_cnt++;
        if (ovr) ovr_cnt++;
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) begin @(posedge clk); #1; end
    endtask

    // Acts as the I2C engine for one transaction and checks the request fields.
    task automatic serve(input string tag, input bit rd, input logic [6:0] dev, input logic [7:0] ra,
                         input logic [7:0] wd, input bit nack, input int nbytes, input int stall,
                         input bit drop_en);
        int waited = 0;
        bit conc;
        while (!bus.TxnReq && waited < 3 * PERIOD) begin cyc(1); waited++; end
        if (!bus.TxnReq) begin
            chk({tag, " req_timeout"}, 32'd0, 32'd1);
            return;
        end
        chk({tag, " read"}, bus.TxnRead, rd);
        chk({tag, " dev"}, bus.TxnDevAddr, dev);
        chk({tag, " reg"}, bus.TxnRegAddr, ra);
        chk({tag, " len"}, bus.TxnLen, rd ? 6 : 0);
        if (!rd) chk({tag, " wdata"}, bus.TxnWrData, wd);
        cyc($urandom_range(0, 2));
        chk({tag, " req_held"}, bus.TxnReq, 1);
        bus.TxnAck = 1'b1;
        cyc(1);
        bus.TxnAck = 1'b0;
        chk({tag, " req_drop"}, bus.TxnReq, 0);
        if (drop_en) en = 1'b0;
        cyc(stall);
        conc = (nbytes > 0) && ($urandom_range(0, 1) == 1);
        for (int i = 0; i < nbytes; i++) begin
            bus.RxByteValid = 1'b1;
            bus.RxByte      = byte_q.pop_front();
            if (conc && i == nbytes - 1) begin
                bus.TxnDone = 1'b1;
                bus.TxnNack = nack;
            end
            cyc(1);
            bus.RxByteValid = 1'b0;
            bus.TxnDone     = 1'b0;
            bus.TxnNack     = 1'b0;
        end
        if (!conc) begin
            bus.TxnDone = 1'b1;
            bus.TxnNack = nack;
            cyc(1);
            bus.TxnDone = 1'b0;
            bus.TxnNack = 1'b0;
        end
    endtask

    task automatic rand_fb();
        for (int i = 0; i < 12; i++) fb[i] = 8'($urandom);
    endtask

    // Reference: accel = low 10 bits of LE word; gyro = BE word / 64, 10 bits.
    task automatic model_publish();
        for (int k = 0; k < 3; k++) begin
            exp_s[k]     = (int'(fb[2*k+1]) % 4) * 256 + int'(fb[2*k]);
            exp_s[3 + k] = ((int'(fb[6+2*k]) * 256 + int'(fb[7+2*k])) / 64) % 1024;
        end
    endtask

    task automatic check_outs(input string tag);
        chk({tag, " AccelX"}, ax, exp_s[0]);
        chk({tag, " AccelY"}, ay, exp_s[1]);
        chk({tag, " AccelZ"}, az, exp_s[2]);
        chk({tag, " GyroX"},  gx, exp_s[3]);
        chk({tag, " GyroY"},  gy, exp_s[4]);
        chk({tag, " GyroZ"},  gz, exp_s[5]);
    endtask

    // One sample frame from fb[]: optional accel NACKs, extra byte, stall, enable drop.
    task automatic frame(input string tag, input int acc_nacks, input bit extra, input int stall,
                         input bit drop_en, input bit exp_pub);
        int dv0 = dv_cnt;
        for (int k = 0; k < acc_nacks; k++)
            serve({tag, " acc_nack"}, 1, 7'h53, 8'h32, 8'h00, 1, 0, 0, 0);
        for (int i = 0; i < 6; i++) byte_q.push_back(fb[i]);
        if (extra) byte_q.push_back(8'($urandom));
        serve({tag, " acc"}, 1, 7'h53, 8'h32, 8'h00, 0, extra ? 7 : 6, stall, 0);
        check_outs({tag, " pre"});
        for (int i = 6; i < 12; i++) byte_q.push_back(fb[i]);
        serve({tag, " gyr"}, 1, 7'h68, 8'h1D, 8'h00, 0, 6, 0, drop_en);
        cyc(4);
        if (exp_pub) model_publish();
        check_outs(tag);
        chk({tag, " dv_pulses"}, dv_cnt - dv0, exp_pub ? 1 : 0);
    endtask

    initial begin
        int dv0;
        int ovr0;
        int waited;
        bus.TxnAck = 1'b0; bus.RxByteValid = 1'b0; bus.RxByte = 8'h00;
        bus.TxnDone = 1'b0; bus.TxnNack = 1'b0;
        for (int k = 0; k < 6; k++) exp_s[k] = 0;

        cyc(3);
        chk("reset TxnReq", bus.TxnReq, 0);
        chk("reset DataValid", dv, 0);
        chk("reset Fault", fault, 0);
        chk("reset Overrun", ovr, 0);
        check_outs("reset");
        rst_n = 1'b1;

        // Init table runs with Enable low.
        serve("init0", 0, 7'h53, 8'h2D, 8'h08, 0, 0, 0, 0);
        serve("init1", 0, 7'h53, 8'h31, 8'h00, 0, 0, 0, 0);
        serve("init2", 0, 7'h68, 8'h3E, 8'h00, 0, 0, 0, 0);
        serve("init3", 0, 7'h68, 8'h16, 8'h18, 0, 0, 0, 0);
        cyc(5);
        chk("init no DataValid", dv_cnt, 0);
        chk("init Fault", fault, 0);
        en = 1'b1;

        fb = '{8'h34, 8'h01, 8'hFE, 8'h03, 8'h00, 8'h02,
               8'h12, 8'hC0, 8'hFF, 8'hC0, 8'h00, 8'h40};
        frame("t2", 0, 0, 0, 0, 1);
        chk("t2 AccelX const", ax, 10'h134);
        chk("t2 AccelY const", ay, 10'h3FE);
        chk("t2 AccelZ const", az, 10'h200);
        chk("t2 GyroX const",  gx, 10'h04B);
        chk("t2 GyroY const",  gy, 10'h3FF);
        chk("t2 GyroZ const",  gz, 10'h001);

        for (int r = 0; r < 5; r++) begin
            rand_fb();
            frame("rnd", 0, (r % 2) == 1, 0, 0, 1);
        end

        rand_fb();
        frame("t3", 2, 0, 0, 0, 1);
        chk("t3 Fault", fault, 0);

        for (int i = 0; i < 5; i++) byte_q.push_back(8'($urandom));
        serve("short acc", 1, 7'h53, 8'h32, 8'h00, 0, 5, 0, 0);
        rand_fb();
        frame("short retry", 0, 0, 0, 0, 1);
        chk("short Fault", fault, 0);

        chk("no overrun yet", ovr_cnt, 0);
        ovr0 = ovr_cnt;
        rand_fb();
        frame("t5", 0, 0, PERIOD - 5, 0, 1);
        chk("t5 overrun pulses", ovr_cnt - ovr0, 1);

        dv0 = dv_cnt;
        for (int k = 0; k < 4; k++)
            serve("t4 nack", 1, 7'h53, 8'h32, 8'h00, 1, 0, 0, 0);
        cyc(4);
        chk("t4 Fault set", fault, 1);
        chk("t4 no DataValid", dv_cnt - dv0, 0);
        check_outs("t4 held");
        rand_fb();
        frame("t4 next", 0, 0, 0, 0, 1);
        chk("t4 Fault sticky", fault, 1);

        rand_fb();
        frame("t6 abort", 0, 0, 0, 1, 0);
        en = 1'b1;
        waited = 0;
        while (!bus.TxnReq && waited < 3 * PERIOD) begin cyc(1); waited++; end
        chk("t6 acc_req seen", bus.TxnReq, 1);
        #3;
        rst_n = 1'b0;
        #1;
        chk("t6 async TxnReq", bus.TxnReq, 0);
        chk("t6 reset DataValid", dv, 0);
        chk("t6 reset Fault", fault, 0);
        chk("t6 reset Overrun", ovr, 0);
        for (int k = 0; k < 6; k++) exp_s[k] = 0;
        check_outs("t6 reset");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
